inst_prefetch: RTL and testbench

Instruction prefetch buffer between the instruction ROM and the fetch stage. Drives the ROM word address ahead of the pipeline and queues returned words with their PCs in a small FIFO. Presents one instruction per cycle to fetch, absorbs pipeline stalls without re-reading ROM, and flushes on a taken branch or jump redirect from writeback.

---
 rtl/inst_prefetch_pkg.sv | 23 ++
 rtl/inst_prefetch_fifo.sv | 79 +++++++
 rtl/inst_prefetch.sv | 122 ++++++++++++
 tb/tb_inst_prefetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetch block and its bench.
//   NOP_INSTR      : bubble word presented to fetch when nothing is queued.
//   DEFAULT_DEPTH  : default FIFO depth (power of two, >= 2).
//   DEFAULT_ROM_AW : default ROM word-address width.
//   fetch_entry_t  : one queued {pc, instr} pair (64 bits).
//   align_word()   : clears the byte-offset bits of an address.
package inst_prefetch_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH  = 4;
    localparam int          DEFAULT_ROM_AW = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word-align a byte address; misaligned low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of {pc, instr} entries for the prefetcher.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push/push_data : write one entry at the end of the cycle
//   pop            : drop the head entry at the end of the cycle
//   flush          : empty the FIFO; dominates push and pop
//   count          : number of valid entries (0..DEPTH)
//   head           : oldest entry (meaningful only when count != 0)
module prefetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointer and occupancy next-state; full/empty guards keep state sane
    // even if a caller misbehaves.
    always_comb begin
        do_push_s = push && !flush && (count_q != CW'(DEPTH));
        do_pop_s  = pop  && !flush && (count_q != {CW{1'b0}});
        if (flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= fetch_entry_t'(64'h0);
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: runs the ROM address ahead of fetch and queues returned
// words with their PCs, presenting one instruction per cycle.
// Ports:
//   clk, rst        : CPU clock, asynchronous active-high reset
//   rom_address     : ROM word address (fetch_pc[ROM_AW+1:2])
//   rom_data        : ROM word, valid one cycle after its address
//   redirect        : taken branch/jump; flushes and restarts at target
//   redirect_target : byte target address (low two bits ignored)
//   stall           : hold the head instruction
//   valid/instr/pc  : head instruction; NOP_INSTR / 0 when not valid
// Optional feature macro: PREFETCH_BYPASS_EN forwards the arriving ROM word
// straight to the outputs when the FIFO is empty (one cycle less latency).
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ROM_AW = DEFAULT_ROM_AW
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    input  logic              stall,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [31:0]       pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inf_q, inf_d;
    logic [31:0]   inf_pc_q, inf_pc_d;
    logic [CW-1:0] fifo_count_s;
    fetch_entry_t  fifo_head_s;
    fetch_entry_t  push_data_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          pop_s;
    logic          bypass_s;
    logic          issue_s;
    logic [CW:0]   credit_s;

    // Output selection, pop/push steering, credit check and issue/redirect
    // next-state.
    always_comb begin
`ifdef PREFETCH_BYPASS_EN
        bypass_s = (fifo_count_s == {CW{1'b0}}) && inf_q;
`else
        bypass_s = 1'b0;
`endif
        if (fifo_count_s != {CW{1'b0}}) begin
            valid = 1'b1;
            instr = fifo_head_s.instr;
            pc    = fifo_head_s.pc;
        end else if (bypass_s) begin
            valid = 1'b1;
            instr = rom_data;
            pc    = inf_pc_q;
        end else begin
            valid = 1'b0;
            instr = NOP_INSTR;
            pc    = 32'h0;
        end

        pop_s       = valid && !stall;
        fifo_pop_s  = pop_s && !bypass_s;
        // A forwarded word consumed this cycle never needs storage.
        fifo_push_s = inf_q && !(bypass_s && pop_s);
        push_data_s = '{pc: inf_pc_q, instr: rom_data};

        // Occupancy after this cycle's push/pop; an issue now must still
        // have a free slot when its word lands next cycle.
        credit_s = {1'b0, fifo_count_s} + (CW+1)'(inf_q) - (CW+1)'(pop_s);
        issue_s  = !redirect && (credit_s < (CW+1)'(DEPTH));

        if (redirect) begin
            fetch_pc_d = align_word(redirect_target);
            inf_d      = 1'b0;
            inf_pc_d   = inf_pc_q;
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            inf_d      = 1'b1;
            inf_pc_d   = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            inf_d      = 1'b0;
            inf_pc_d   = inf_pc_q;
        end
    end

    // Fetch PC and in-flight tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= 32'h0;
            inf_q      <= 1'b0;
            inf_pc_q   <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inf_q      <= inf_d;
            inf_pc_q   <= inf_pc_d;
        end
    end

    assign rom_address = fetch_pc_q[ROM_AW+1:2];

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .pop       (fifo_pop_s),
        .flush     (redirect),
        .push_data (push_data_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;
    import inst_prefetch_pkg::*;

    localparam int DEPTH  = DEFAULT_DEPTH;
    localparam int ROM_AW = DEFAULT_ROM_AW;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP           = 1'b1;
    localparam int EXP_ADDR_LAT  = 1;
    localparam int EXP_REDIR_LAT = 2;
`else
    localparam bit BYP           = 1'b0;
    localparam int EXP_ADDR_LAT  = 2;
    localparam int EXP_REDIR_LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ROM_AW-1:0] rom_address;
    logic [31:0]       rom_data = 32'h0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_target = 32'h0;
    logic              stall = 1'b0;
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_fetch_pc;
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [63:0] m_q[$];

    inst_prefetch #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_address     (rom_address),
        .rom_data        (rom_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .valid           (valid),
        .instr           (instr),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    // synchronous ROM: word k holds 0x1000 + k
    always @(posedge clk) rom_data <= 32'h0000_1000 + 32'(rom_address);

    function automatic logic [31:0] rom_word(input logic [31:0] p);
        return 32'h0000_1000 + 32'(p[ROM_AW+1:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inf      = 1'b0;
        m_inf_pc   = 32'h0;
        m_fetch_pc = 32'h0;
    endtask

    // Called at posedge+1. Asserts reset asynchronously and checks that the
    // outputs collapse immediately, without waiting for a clock edge.
    task automatic do_reset();
        #1;
        rst = 1'b1; redirect = 1'b0; stall = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_rom_address", 32'(rom_address), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, compare against the model at the falling
    // edge, advance the model, then move to just after the next rising edge.
    task automatic step(input logic rd, input logic [31:0] tgt, input logic st,
                        output logic ov, output logic [31:0] opc,
                        output logic [31:0] oi, output logic [ROM_AW-1:0] oa);
        bit          ev, pop, byp_pop;
        logic [31:0] epc, ein;
        int          occ;
        redirect = rd; redirect_target = tgt; stall = st;
        @(negedge clk);
        if (m_q.size() > 0) begin
            ev = 1'b1; epc = m_q[0][63:32]; ein = m_q[0][31:0];
        end else if (BYP && m_inf) begin
            ev = 1'b1; epc = m_inf_pc; ein = rom_word(m_inf_pc);
        end else begin
            ev = 1'b0; epc = 32'h0; ein = 32'h0000_0013;
        end
        chk("valid", 32'(valid), 32'(ev));
        chk("pc", pc, epc);
        chk("instr", instr, ein);
        chk("rom_address", 32'(rom_address), 32'(m_fetch_pc[ROM_AW+1:2]));
        ov = valid; opc = pc; oi = instr; oa = rom_address;
        pop = ev && !st;
        if (rd) begin
            m_q.delete();
            m_inf      = 1'b0;
            m_fetch_pc = {tgt[31:2], 2'b00};
        end else begin
            occ     = int'(m_q.size()) + int'(m_inf) - int'(pop);
            byp_pop = (m_q.size() == 0) && pop;
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_inf && !byp_pop) m_q.push_back({m_inf_pc, rom_word(m_inf_pc)});
            if (occ < DEPTH) begin
                m_inf      = 1'b1;
                m_inf_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end else begin
                m_inf = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    // Redirect, then measure cycles until the first target instruction.
    task automatic redirect_lat(input logic [31:0] tgt, input logic st, input logic [31:0] exp_pc);
        logic              ov;
        logic [31:0]       opc, oi;
        logic [ROM_AW-1:0] oa;
        int                first;
        step(1'b1, tgt, st, ov, opc, oi, oa);
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 32'h0, 1'b0, ov, opc, oi, oa);
            if (k == 1) begin
                chk("redir_valid_low", 32'(ov), 32'h0);
                chk("redir_rom_address", 32'(oa), 32'(exp_pc[ROM_AW+1:2]));
            end
            if (k == 2) chk("redir_rom_address_next", 32'(oa), 32'(((exp_pc + 32'd4) >> 2) % (1 << ROM_AW)));
            if (first >= 0 && k == first + 1) chk("redir_second_pc", opc, exp_pc + 32'd4);
            if (ov && first < 0) begin
                first = k;
                chk("redir_first_pc", opc, exp_pc);
                chk("redir_first_instr", oi, 32'h0000_1000 + ((exp_pc >> 2) % (1 << ROM_AW)));
            end
        end
        chk("redirect_to_valid", 32'(first), 32'(EXP_REDIR_LAT));
    endtask

    initial begin
        logic              ov;
        logic [31:0]       opc, oi;
        logic [ROM_AW-1:0] oa, oa5;
        int                first;
        logic              rd, st;
        logic [31:0]       tgt;

        @(posedge clk); #1;
        do_reset();

        // priming: address-to-valid latency and the first few PCs
        first = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b0, ov, opc, oi, oa);
            if (ov && first < 0) begin
                first = i;
                chk("first_pc", opc, 32'h0);
                chk("first_instr", oi, 32'h0000_1000);
            end
            if (first >= 0 && i > first) chk("stream_pc", opc, 32'((i - first) * 4));
        end
        chk("addr_to_valid", 32'(first), 32'(EXP_ADDR_LAT));

        // long stall: ROM address must stop once the credit is used up
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1, ov, opc, oi, oa);
            if (i == 5) oa5 = oa;
            if (i == 9) chk("stall_addr_frozen", 32'(oa), 32'(oa5));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, ov, opc, oi, oa);

        // build up a partly filled FIFO, then redirect
        step(1'b0, 32'h0, 1'b1, ov, opc, oi, oa);
        step(1'b0, 32'h0, 1'b1, ov, opc, oi, oa);
        redirect_lat(32'h0000_0040, 1'b0, 32'h0000_0040);

        // redirect wins over stall; misaligned target is aligned
        redirect_lat(32'h0000_0083, 1'b1, 32'h0000_0080);

        // ROM address wraps, PC does not
        redirect_lat(32'h0000_03FC, 1'b0, 32'h0000_03FC);

        // randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                rd  = ($urandom_range(0, 99) < 5);
                st  = ($urandom_range(0, 99) < 30);
                tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
                step(rd, tgt, st, ov, opc, oi, oa);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
